// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        DIV_BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic pc_hold;
        logic fd_stall;
        logic de_stall;
        logic em_stall;
        logic fd_flush;
        logic de_flush;
        logic em_flush;
        logic mw_flush;
    } ctrl_t;

    localparam int DIV_LAT_DEF    = 32;
    localparam int DM_TIMEOUT_DEF = 255;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds the decode instruction.
import pipe_ctrl_pkg::*;

module hazard_detect (
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       use_rs1_i,
    input  logic       use_rs2_i,
    input  logic [4:0] rd_i,
    input  logic       mem_read_i,
    output logic       load_use_o
);

    assign load_use_o = mem_read_i && (rd_i != 5'd0) &&
                        ((use_rs1_i && (rs1_i == rd_i)) || (use_rs2_i && (rs2_i == rd_i)));

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the five-stage pipeline with data-memory timeout.
// Divide sequencing is built only when PIPE_CTRL_MULDIV_EN is defined.
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
    parameter int DIV_LAT    = DIV_LAT_DEF,
    parameter int DM_TIMEOUT = DM_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] D_rs1,
    input  logic [4:0] D_rs2,
    input  logic       D_use_rs1,
    input  logic       D_use_rs2,
    input  logic [4:0] E_rd,
    input  logic       E_mem_read,
    input  logic       E_branch_taken,
    input  logic       E_div_start,
    input  logic       M_dm_req,
    input  logic       dm_ready,
    output logic       pc_hold,
    output logic       FD_stall,
    output logic       DE_stall,
    output logic       EM_stall,
    output logic       FD_flush,
    output logic       DE_flush,
    output logic       EM_flush,
    output logic       MW_flush,
    output logic       div_busy,
    output logic       div_done,
    output logic       dm_timeout
);

    localparam int WW = $clog2(DM_TIMEOUT + 1);

    logic          dm_stall;
    logic          load_use;
    logic          div_hold;
    logic          div_done_c;
    logic          div_busy_c;
    ctrl_t         ctrl;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          dm_timeout_q, dm_timeout_d;

    assign dm_stall = M_dm_req & ~dm_ready;

    hazard_detect u_hazard_detect (
        .rs1_i      (D_rs1),
        .rs2_i      (D_rs2),
        .use_rs1_i  (D_use_rs1),
        .use_rs2_i  (D_use_rs2),
        .rd_i       (E_rd),
        .mem_read_i (E_mem_read),
        .load_use_o (load_use)
    );

`ifdef PIPE_CTRL_MULDIV_EN
    localparam int CW = $clog2(DIV_LAT);

    state_e        state_q, state_d;
    logic [CW-1:0] div_cnt_q, div_cnt_d;

    // A memory stall freezes the divide sequence, which also defers div_done.
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        div_hold   = 1'b0;
        div_done_c = 1'b0;
        if (!dm_stall) begin
            case (state_q)
                RUN: begin
                    if (E_div_start) begin
                        div_hold  = 1'b1;
                        state_d   = DIV_BUSY;
                        div_cnt_d = CW'(DIV_LAT - 1);
                    end
                end
                default: begin
                    if (div_cnt_q != '0) begin
                        div_hold  = 1'b1;
                        div_cnt_d = div_cnt_q - 1'b1;
                    end else begin
                        div_done_c = 1'b1;
                        state_d    = RUN;
                    end
                end
            endcase
        end
        div_busy_c = (state_q == DIV_BUSY) | ((state_q == RUN) & E_div_start & ~dm_stall);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            div_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
        end
    end
`else
    localparam int unused_div_lat = DIV_LAT;
    logic unused_div_start;

    assign unused_div_start = E_div_start;
    assign div_hold         = 1'b0;
    assign div_done_c       = 1'b0;
    assign div_busy_c       = 1'b0;
`endif

    always_comb begin
        if (dm_stall) begin
            wait_cnt_d = (wait_cnt_q == WW'(DM_TIMEOUT)) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_d = '0;
        end
        dm_timeout_d = dm_timeout_q | (wait_cnt_d == WW'(DM_TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q   <= '0;
            dm_timeout_q <= 1'b0;
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            dm_timeout_q <= dm_timeout_d;
        end
    end

    // Priority chain: memory wait, divide, branch redirect, load-use.
    always_comb begin
        ctrl = '0;
        if (dm_stall) begin
            ctrl.pc_hold  = 1'b1;
            ctrl.fd_stall = 1'b1;
            ctrl.de_stall = 1'b1;
            ctrl.em_stall = 1'b1;
            ctrl.mw_flush = 1'b1;
        end else if (div_hold) begin
            ctrl.pc_hold  = 1'b1;
            ctrl.fd_stall = 1'b1;
            ctrl.de_stall = 1'b1;
            ctrl.em_flush = 1'b1;
        end else if (E_branch_taken) begin
            ctrl.fd_flush = 1'b1;
            ctrl.de_flush = 1'b1;
        end else if (load_use) begin
            ctrl.pc_hold  = 1'b1;
            ctrl.fd_stall = 1'b1;
            ctrl.de_flush = 1'b1;
        end
        if (rst) begin
            ctrl = '0;
        end
    end

    assign pc_hold    = ctrl.pc_hold;
    assign FD_stall   = ctrl.fd_stall;
    assign DE_stall   = ctrl.de_stall;
    assign EM_stall   = ctrl.em_stall;
    assign FD_flush   = ctrl.fd_flush;
    assign DE_flush   = ctrl.de_flush;
    assign EM_flush   = ctrl.em_flush;
    assign MW_flush   = ctrl.mw_flush;
    assign div_busy   = div_busy_c & ~rst;
    assign div_done   = div_done_c & ~rst;
    assign dm_timeout = dm_timeout_q & ~rst;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a scoreboard of expected control vectors.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] D_rs1, D_rs2, E_rd;
    logic       D_use_rs1, D_use_rs2, E_mem_read, E_branch_taken, E_div_start;
    logic       M_dm_req, dm_ready;
    logic       pc_hold, FD_stall, DE_stall, EM_stall;
    logic       FD_flush, DE_flush, EM_flush, MW_flush;
    logic       div_busy, div_done, dm_timeout;

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    pipe_ctrl #(.DIV_LAT(4), .DM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .D_rs1(D_rs1), .D_rs2(D_rs2), .D_use_rs1(D_use_rs1), .D_use_rs2(D_use_rs2),
        .E_rd(E_rd), .E_mem_read(E_mem_read), .E_branch_taken(E_branch_taken),
        .E_div_start(E_div_start), .M_dm_req(M_dm_req), .dm_ready(dm_ready),
        .pc_hold(pc_hold), .FD_stall(FD_stall), .DE_stall(DE_stall), .EM_stall(EM_stall),
        .FD_flush(FD_flush), .DE_flush(DE_flush), .EM_flush(EM_flush), .MW_flush(MW_flush),
        .div_busy(div_busy), .div_done(div_done), .dm_timeout(dm_timeout)
    );

    // Vector order: pc_hold FD_stall DE_stall EM_stall FD_flush DE_flush EM_flush MW_flush busy done timeout
    localparam logic [10:0] NONE = 11'b0000_0000_000;
    localparam logic [10:0] LU   = 11'b1100_0100_000;
    localparam logic [10:0] BR   = 11'b0000_1100_000;
    localparam logic [10:0] DM   = 11'b1111_0001_000;
    localparam logic [10:0] DV   = 11'b1110_0010_100;
    localparam logic [10:0] BUSY = 11'b0000_0000_100;
    localparam logic [10:0] DONE = 11'b0000_0000_110;
    localparam logic [10:0] TO   = 11'b0000_0000_001;

    task automatic cyc(input logic [10:0] exp, input string tag);
        logic [10:0] obs;
        logic [10:0] e;
        string       t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        obs = {pc_hold, FD_stall, DE_stall, EM_stall, FD_flush, DE_flush, EM_flush,
               MW_flush, div_busy, div_done, dm_timeout};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", t, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        D_rs1 = 5'd0; D_rs2 = 5'd0; D_use_rs1 = 1'b0; D_use_rs2 = 1'b0;
        E_rd = 5'd0; E_mem_read = 1'b0; E_branch_taken = 1'b0; E_div_start = 1'b0;
        M_dm_req = 1'b0; dm_ready = 1'b1;
    endtask

    task automatic set_lu(input logic [4:0] r);
        D_rs1 = r; D_use_rs1 = 1'b1; E_rd = r; E_mem_read = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b1;
        set_lu(5'd5); E_branch_taken = 1'b1; M_dm_req = 1'b1; dm_ready = 1'b0;
        cyc(NONE, "reset_busy_inputs");
        cyc(NONE, "reset_hold");
        idle();
        cyc(NONE, "reset_still_high");
        rst = 1'b0;
        cyc(NONE, "idle_after_reset");

        set_lu(5'd5);
        cyc(LU, "loaduse_rs1");
        E_mem_read = 1'b0;
        cyc(NONE, "loaduse_one_bubble");
        set_lu(5'd0);
        cyc(NONE, "loaduse_x0");
        idle(); D_rs2 = 5'd7; D_use_rs2 = 1'b1; E_rd = 5'd7; E_mem_read = 1'b1;
        cyc(LU, "loaduse_rs2");
        D_use_rs2 = 1'b0;
        cyc(NONE, "loaduse_rs2_unused");
        D_use_rs2 = 1'b1; E_rd = 5'd8;
        cyc(NONE, "loaduse_rd_mismatch");

        idle(); set_lu(5'd5); E_branch_taken = 1'b1;
        cyc(BR, "branch_over_loaduse");
        idle(); E_branch_taken = 1'b1;
        cyc(BR, "branch_only");

        idle(); set_lu(5'd5); E_branch_taken = 1'b1; M_dm_req = 1'b1; dm_ready = 1'b0;
        cyc(DM, "dmstall_over_all");
        dm_ready = 1'b1; E_branch_taken = 1'b0;
        cyc(LU, "loaduse_after_dmstall");
        idle(); dm_ready = 1'b0;
        cyc(NONE, "no_req_no_stall");

        M_dm_req = 1'b1; dm_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc(DM, "dmstall_3");
        dm_ready = 1'b1;
        cyc(NONE, "no_timeout_after_3");

        dm_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc(DM, "dmstall_pre_timeout");
        for (int i = 0; i < 2; i++) cyc(DM | TO, "dmstall_timeout_set");
        dm_ready = 1'b1;
        cyc(TO, "timeout_sticky_1");
        idle();
        cyc(TO, "timeout_sticky_2");
        rst = 1'b1;
        cyc(NONE, "timeout_in_reset");
        rst = 1'b0;
        cyc(NONE, "timeout_cleared");

`ifdef PIPE_CTRL_MULDIV_EN
        idle(); E_div_start = 1'b1;
        for (int i = 0; i < 4; i++) cyc(DV, "div_hold");
        cyc(DONE, "div_done");
        E_div_start = 1'b0;
        cyc(NONE, "div_no_restart");

        E_div_start = 1'b1; M_dm_req = 1'b1; dm_ready = 1'b0;
        cyc(DM, "div_start_under_dmstall");
        dm_ready = 1'b1;
        cyc(DV, "div_c1");
        E_branch_taken = 1'b1;
        cyc(DV, "div_c2_branch_masked");
        E_branch_taken = 1'b0; dm_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc(DM | BUSY, "div_frozen_by_dm");
        dm_ready = 1'b1;
        cyc(DV, "div_c3");
        cyc(DV, "div_c4");
        E_branch_taken = 1'b1;
        cyc(DONE | BR, "div_done_delayed_branch");
        idle();
        cyc(NONE, "div_after_delayed_done");

        E_div_start = 1'b1;
        for (int i = 0; i < 4; i++) cyc(DV, "div2_hold");
        M_dm_req = 1'b1; dm_ready = 1'b0;
        cyc(DM | BUSY, "dm_on_done_cycle");
        dm_ready = 1'b1;
        cyc(DONE, "div_done_after_dm");
        idle();
        cyc(NONE, "div2_idle");

        E_div_start = 1'b1;
        cyc(DV, "div3_run");
        cyc(DV, "div3_busy1");
        rst = 1'b1;
        cyc(NONE, "reset_mid_div");
        rst = 1'b0; E_div_start = 1'b0;
        for (int i = 0; i < 5; i++) cyc(NONE, "no_done_after_reset");
`else
        idle(); E_div_start = 1'b1;
        cyc(NONE, "div_disabled");
        set_lu(5'd9);
        cyc(LU, "div_disabled_loaduse");
        idle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
